gol_frame_writer: RTL
=====================

# gol_frame_writer

Write-side frame store for the Game of Life display path. It accepts next-generation pixel values from the life engine over a valid/ready stream and writes them in raster order into the back bank of a double-buffered 64 × 8-bit memory. On a display frame tick it swaps banks so that the display reads a complete, stable generation. It is the producer-side counterpart of the frame-0 memory read path, and it supplies the `pixel_value` source for frames after the initial state.

## Interface
- `WIDTH`, default 8, grid columns
- `HEIGHT`, default 8, grid rows; `CELLS = WIDTH*HEIGHT` = 64, and the address width is `$clog2(CELLS)` = 6
- `DATA_W`, default 8, pixel width
- `clk`  in  1  system clock; everything is sampled on its rising edge
- `reset`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  a pixel is offered on `in_pixel`
- `in_pixel`  in  DATA_W  pixel value for the current write address
- `in_ready`  out  1  the block can accept a pixel this cycle
- `frame_tick`  in  1  one-cycle display frame boundary (swap request)
- `rd_address`  in  6  display read address, raster order (row*WIDTH+col)
- `rd_data`  out  DATA_W  front-bank pixel, registered
- `front_valid`  out  1  the front bank holds a completed generation
- `frame_done`  out  1  one-cycle pulse on the cycle after a bank swap
- `frame_count`  out  8  number of completed swaps, wraps modulo 256
- `wr_address`  out  6  next back-bank address to be written (debug/monitor)

## Operation
- Storage: two banks, each `mem[0:CELLS-1]` of `DATA_W` bits. `front_sel` names the display bank; the back bank is `!front_sel`. Memory contents are not reset.
- The state machine has two states, WRITE and FULL. Reset enters WRITE.
- WRITE:
  - `in_ready` = 1.
  - On `in_valid && in_ready`, write `in_pixel` to back[`wr_address`] and increment `wr_address`.
  - On the accept at address CELLS-1, `wr_address` wraps to 0 and the state goes to FULL.
  - `frame_tick` is ignored in WRITE. The display keeps showing the current front bank, so a partial generation is never swapped in.
- FULL:
  - `in_ready` = 0, and `in_valid` is ignored with no write.
  - On `frame_tick`: toggle `front_sel`, set `front_valid` = 1, increment `frame_count` (255→0), assert `frame_done` the next cycle, and go to WRITE with `wr_address` = 0.
- A `frame_tick` coincident with the CELLS-1 accept is ignored (the state is still WRITE at that edge). The swap waits for the next tick.
- Read path: at each edge, `rd_data` <= mem[`front_sel`][`rd_address`], using the `front_sel` value held before that edge. A read sampled on the same edge as a swap returns old front-bank data. The next read returns the new bank.
- `rd_data` is meaningful only while `front_valid` = 1. Before the first swap its value is undefined apart from the reset value.
- Back-bank writes never alias the front bank. The front bank is read-only while selected.
- `in_valid` may deassert mid-frame. `wr_address` holds, and there is no timeout.

## Timing
- Reset values, applied asynchronously while `reset` = 1:
  - state = WRITE
  - `in_ready` = 1
  - `wr_address` = 0
  - `front_sel` = 0
  - `front_valid` = 0
  - `frame_done` = 0
  - `frame_count` = 0
  - `rd_data` = 0
- Reset asserted mid-frame discards partial back-bank progress. The bank contents are left as-is, but `front_valid` = 0 hides them.
- Write latency: the pixel is in memory at the accepting edge. Minimum frame fill is CELLS (64) consecutive accept cycles.
- `in_ready` is decoded from state only. Its first low cycle is the cycle after the CELLS-1 accept, and its first high cycle is the cycle after the swap edge.
- Swap: a tick sampled in FULL at edge N gives the new `front_sel`, `frame_count` and `front_valid` from edge N. `frame_done` is high for exactly the cycle after edge N.
- Read latency: 1 cycle from `rd_address` to `rd_data`.

## Test plan
- Reset then idle:
  - Outputs: `in_ready`=1, `front_valid`=0, `frame_count`=0, `frame_done`=0, `wr_address`=0.
  - Toggling `frame_tick` must change nothing.
- Fill 64 pixels with value = address (0x00..0x3F), continuous valid:
  - `in_ready` drops the cycle after the 64th accept.
  - A tick then gives `frame_done` for 1 cycle and `frame_count`=1.
  - Reading addresses 0..63 returns 0x00..0x3F with 1-cycle latency.
- Double buffering:
  - Write and swap frame A (all 0xAA). Then write half of frame B (0x55) and pulse the tick mid-write.
  - `rd_data` stays 0xAA everywhere and `frame_count` stays 1.
  - After completing B, a tick makes reads return 0x55.
- Backpressure in FULL: hold `in_valid`=1 with `in_pixel`=0xFF for 10 cycles, then tick and read the new front bank. No 0xFF appears, and the next frame writes start at address 0.
- Coincident tick: tick on the same cycle as the 64th accept. There is no swap, `frame_count` is unchanged, and a tick two cycles later swaps.
- Reset mid-frame (after 20 accepts, `front_valid`=1):
  - Outputs return to reset values at once, with `front_valid`=0.
  - A subsequent full fill plus tick gives `frame_count`=1 and correct data.
- Wrap: 256 fill/swap cycles make `frame_count` wrap to 0, with `frame_done` pulsing each time.

Source files
------------

// File: rtl/gol_frame_writer.sv
// Double-buffered Game of Life frame store: raster-order back-bank writes, bank swap on frame tick.
// Writes land at the accepting edge, reads take 1 cycle; in_ready stays low from a full back bank until the swap.
module gol_frame_writer #(
   parameter int WIDTH  = 8,
   parameter int HEIGHT = 8,
   parameter int DATA_W = 8,
   localparam int CELLS = WIDTH * HEIGHT,
   localparam int AW    = $clog2(CELLS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_pixel,
   output logic              in_ready,
   input  logic              frame_tick,
   input  logic [AW-1:0]     rd_address,
   output logic [DATA_W-1:0] rd_data,
   output logic              front_valid,
   output logic              frame_done,
   output logic [7:0]        frame_count,
   output logic [AW-1:0]     wr_address
);

   typedef enum logic {ST_WRITE = 1'b0, ST_FULL = 1'b1} state_t;

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_addr_q, wr_addr_d;
   logic                front_sel_q, front_sel_d;
   logic                front_valid_q, front_valid_d;
   logic                frame_done_q, frame_done_d;
   logic [7:0]          frame_count_q, frame_count_d;
   logic [DATA_W-1:0]   rd_data_q;

   // Bank select is the top address bit; the bank written is always the one not on display.
   logic [DATA_W-1:0]   mem_q [0:(2**(AW+1))-1];

   logic accept, last_cell, swap;

   assign accept    = in_valid && (state_q == ST_WRITE);
   assign last_cell = (wr_addr_q == AW'(CELLS - 1));
   assign swap      = frame_tick && (state_q == ST_FULL);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_WRITE;
      else       state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_WRITE: if (accept && last_cell) state_d = ST_FULL;
         ST_FULL:  if (frame_tick)          state_d = ST_WRITE;
         default:                           state_d = ST_WRITE;
      endcase
   end

   always_comb begin
      in_ready = (state_q == ST_WRITE);
   end

   always_comb begin
      wr_addr_d = wr_addr_q;
      if (accept) wr_addr_d = last_cell ? '0 : wr_addr_q + AW'(1);
      if (swap)   wr_addr_d = '0;
      front_sel_d   = front_sel_q ^ swap;
      front_valid_d = front_valid_q | swap;
      frame_count_d = frame_count_q + 8'(swap);
      frame_done_d  = swap;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_addr_q     <= '0;
         front_sel_q   <= 1'b0;
         front_valid_q <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= 8'd0;
         rd_data_q     <= '0;
      end else begin
         wr_addr_q     <= wr_addr_d;
         front_sel_q   <= front_sel_d;
         front_valid_q <= front_valid_d;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         rd_data_q     <= mem_q[{front_sel_q, rd_address}];
      end
   end

   always_ff @(posedge clk) begin
      if (accept) mem_q[{~front_sel_q, wr_addr_q}] <= in_pixel;
   end

   assign rd_data     = rd_data_q;
   assign front_valid = front_valid_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign wr_address  = wr_addr_q;

endmodule
